// File: rtl/ic245_bus_arbiter.sv
// Round-robin owner arbiter for a '245-style bidirectional transceiver.
// It sequences DIR and active-low OE with a turnaround guard, and can revoke a grant after HOLD_MAX cycles.
module ic245_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned HOLD_MAX    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic dir,
    output logic noe,
    output logic busy,
    output logic timeout
);

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, DRAIN} state_t;

    state_t     r_state;
    logic       r_req_a;
    logic       r_req_b;
    logic       r_own_a;
    logic       r_last_a;
    logic [3:0] r_turn_cnt;
    logic [7:0] r_hold_cnt;

    logic w_any;
    logic w_pick_a;
    logic w_own_req;
    logic w_hold_hit;

    // Requests are registered once, and the FSM acts on the registered copy.
    // This registration stage produces the 1+TURN_CYCLES request-to-grant latency.
    assign w_any      = r_req_a | r_req_b;
    assign w_pick_a   = r_req_a & (~r_req_b | ~r_last_a);
    assign w_own_req  = r_own_a ? r_req_a : r_req_b;
    assign w_hold_hit = (HOLD_MAX != 0) && (r_hold_cnt == 8'(HOLD_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_req_a    <= 1'b0;
            r_req_b    <= 1'b0;
            r_own_a    <= 1'b0;
            r_last_a   <= 1'b0;
            r_turn_cnt <= '0;
            r_hold_cnt <= '0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            dir        <= 1'b1;
            noe        <= 1'b1;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_req_a <= req_a;
            r_req_b <= req_b;
            timeout <= 1'b0;
            case (r_state)
                IDLE, DRAIN: begin
                    if (w_any) begin
                        r_state    <= SETUP;
                        r_own_a    <= w_pick_a;
                        dir        <= w_pick_a;
                        busy       <= 1'b1;
                        r_turn_cnt <= 4'd1;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                SETUP: begin
                    if (r_turn_cnt == 4'(TURN_CYCLES)) begin
                        r_state    <= ACTIVE;
                        noe        <= 1'b0;
                        gnt_a      <= r_own_a;
                        gnt_b      <= ~r_own_a;
                        r_last_a   <= r_own_a;
                        r_hold_cnt <= 8'd1;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 4'd1;
                    end
                end
                ACTIVE: begin
                    if (!w_own_req || w_hold_hit) begin
                        r_state <= DRAIN;
                        noe     <= 1'b1;
                        gnt_a   <= 1'b0;
                        gnt_b   <= 1'b0;
                        timeout <= w_own_req && w_hold_hit;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ic245_bus_arbiter.sv
// Directed bench for ic245_bus_arbiter. One instance uses the defaults; a second instance uses HOLD_MAX=0.
module tb_ic245_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic req_a, req_b, gnt_a, gnt_b, dir, noe, busy, timeout;
    logic req0_a, req0_b, gnt0_a, gnt0_b, dir0, noe0, busy0, timeout0;
    logic [5:0] o1, o0;
    logic p_noe = 1'b1, p_dir = 1'b1, p0_noe = 1'b1, p0_dir = 1'b1;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ic245_bus_arbiter u_dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .dir(dir), .noe(noe),
        .busy(busy), .timeout(timeout)
    );

    ic245_bus_arbiter #(.HOLD_MAX(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_a(req0_a), .req_b(req0_b),
        .gnt_a(gnt0_a), .gnt_b(gnt0_b), .dir(dir0), .noe(noe0),
        .busy(busy0), .timeout(timeout0)
    );

    // Output vector layout: {gnt_a, gnt_b, dir, noe, busy, timeout}.
    assign o1 = {gnt_a, gnt_b, dir, noe, busy, timeout};
    assign o0 = {gnt0_a, gnt0_b, dir0, noe0, busy0, timeout0};

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_vec++;
        assert (!(gnt_a && gnt_b) && (noe === !(gnt_a || gnt_b))) else begin
            n_bad++;
            $error("FAIL inv_gnt: observed gnt_a=%b gnt_b=%b noe=%b expected exclusive gnt with noe=~gnt", gnt_a, gnt_b, noe);
        end
        n_vec++;
        assert (!(p_noe === 1'b0 && noe === 1'b0 && dir !== p_dir)) else begin
            n_bad++;
            $error("FAIL inv_dir: observed dir=%b expected %b while noe low", dir, p_dir);
        end
        n_vec++;
        assert (!(gnt0_a && gnt0_b) && (noe0 === !(gnt0_a || gnt0_b))) else begin
            n_bad++;
            $error("FAIL inv_gnt0: observed gnt_a=%b gnt_b=%b noe=%b expected exclusive gnt with noe=~gnt", gnt0_a, gnt0_b, noe0);
        end
        n_vec++;
        assert (!(p0_noe === 1'b0 && noe0 === 1'b0 && dir0 !== p0_dir)) else begin
            n_bad++;
            $error("FAIL inv_dir0: observed dir=%b expected %b while noe low", dir0, p0_dir);
        end
        p_noe = noe; p_dir = dir; p0_noe = noe0; p0_dir = dir0;
    endtask

    task automatic step(input string tag, input logic [5:0] exp);
        tick();
        chk(tag, o1, exp);
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; req0_a = 1'b0; req0_b = 1'b0;
        tick(); tick();
        chk("reset", o1, 6'b001100);
        chk("reset0", o0, 6'b001100);

        // Single A request: 1 + TURN_CYCLES latency.
        rst_n = 1'b1; req_a = 1'b1;
        step("a_e0_idle", 6'b001100);
        step("a_e1_setup", 6'b001110);
        step("a_e2_setup", 6'b001110);
        step("a_e3_gnt", 6'b101010);
        req_a = 1'b0;
        step("a_e4_hold", 6'b101010);
        step("a_e5_drain", 6'b001110);
        step("a_e6_idle", 6'b001100);

        // Tie after reset: A first, then B after drain with dir flipped.
        rst_n = 1'b0;
        step("tie_reset", 6'b001100);
        rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1;
        step("tie_e0", 6'b001100);
        step("tie_setup_a1", 6'b001110);
        step("tie_setup_a2", 6'b001110);
        step("tie_gnt_a", 6'b101010);
        req_a = 1'b0;
        step("tie_hold_a", 6'b101010);
        step("tie_drain", 6'b001110);
        step("tie_setup_b1", 6'b000110);
        step("tie_setup_b2", 6'b000110);
        step("tie_gnt_b", 6'b010010);
        req_b = 1'b0;
        step("tie_hold_b", 6'b010010);
        step("tie_drain_b", 6'b000110);
        step("tie_idle_dir", 6'b000100);

        // Timeout at HOLD_MAX=16, then the other side is granted.
        req_a = 1'b1; req_b = 1'b1;
        step("to_e0", 6'b000100);
        step("to_setup1", 6'b001110);
        step("to_setup2", 6'b001110);
        step("to_gnt_a", 6'b101010);
        for (int i = 0; i < 15; i++) step("to_hold_a", 6'b101010);
        step("to_pulse", 6'b001111);
        step("to_setup_b1", 6'b000110);
        step("to_setup_b2", 6'b000110);
        step("to_gnt_b", 6'b010010);
        req_a = 1'b0; req_b = 1'b0;
        step("to_hold_b", 6'b010010);
        step("to_drain_b", 6'b000110);
        step("to_idle", 6'b000100);

        // Owner drops during SETUP: turnaround completes, one ACTIVE cycle.
        req_a = 1'b1;
        step("sd_e0", 6'b000100);
        req_a = 1'b0;
        step("sd_setup1", 6'b001110);
        step("sd_setup2", 6'b001110);
        step("sd_active1", 6'b101010);
        step("sd_drain", 6'b001110);
        step("sd_idle", 6'b001100);

        // HOLD_MAX=0: long B ownership with no timeout.
        req0_b = 1'b1;
        tick(); chk("u0_e0", o0, 6'b001100);
        tick(); chk("u0_setup1", o0, 6'b000110);
        tick(); chk("u0_setup2", o0, 6'b000110);
        tick(); chk("u0_gnt_b", o0, 6'b010010);
        for (int i = 0; i < 300; i++) begin
            tick(); chk("u0_hold_b", o0, 6'b010010);
        end

        // Reset mid-ACTIVE: immediate release, no DRAIN.
        rst_n = 1'b0;
        tick(); chk("u0_rst_active", o0, 6'b001100);
        req0_b = 1'b0;
        tick(); chk("u0_rst_hold", o0, 6'b001100);
        rst_n = 1'b1;
        tick(); chk("u0_after_rst", o0, 6'b001100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ic245_bus_arbiter.md
IC245_BUS_ARBITER -- requirements
Module: ic245_bus_arbiter

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 2, legal 1..15: cycles noe stays high with dir settled before enabling.
REQ-002 SHALL have parameter HOLD_MAX, default 16, legal 0..255: max ACTIVE cycles per grant; 0 = unlimited.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port req_a  input  1  A-side requester wants to drive A->B.
REQ-007 SHALL have port req_b  input  1  B-side requester wants to drive B->A.
REQ-008 SHALL have port gnt_a  output  1  A-side owns bus, transceiver enabled A->B.
REQ-009 SHALL have port gnt_b  output  1  B-side owns bus, transceiver enabled B->A.
REQ-010 SHALL have port dir  output  1  to transceiver DIR pin; 1 = A->B, 0 = B->A.
REQ-011 SHALL have port noe  output  1  to transceiver active-low output-enable pin.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Function
REQ-014 SHALL implement states IDLE, SETUP, ACTIVE, DRAIN; all outputs registered.
REQ-015 SHALL, in IDLE with any req high, pick winner and go to SETUP next edge; no req -> stay IDLE.
REQ-016 SHALL arbitrate round-robin: single requester wins; both high -> the side not served last wins; last_owner updates on entry to ACTIVE.
REQ-017 SHALL, in SETUP, hold noe=1, drive dir to winner direction from the first SETUP cycle, stay exactly TURN_CYCLES cycles, then enter ACTIVE.
REQ-018 SHALL, in ACTIVE, drive noe=0 and assert only the winner's gnt, in the same cycle.
REQ-019 SHALL leave ACTIVE to DRAIN when the owner's req is sampled low; gnt and noe deassert in the DRAIN cycle.
REQ-020 SHALL count ACTIVE cycles; when HOLD_MAX!=0 and count reaches HOLD_MAX with req still high, go to DRAIN and pulse timeout in the DRAIN cycle.
REQ-021 SHALL hold DRAIN exactly 1 cycle (noe=1, gnts 0), then go to SETUP with fresh arbitration if any req high, else IDLE.
REQ-022 SHALL retain dir unchanged in IDLE and DRAIN; dir SHALL change only in SETUP-entry while noe=1.
REQ-023 SHALL never assert gnt_a and gnt_b together, never assert noe=0 outside ACTIVE.
REQ-024 SHALL give req-to-gnt latency of 1+TURN_CYCLES cycles from IDLE (req sampled at edge n, gnt high after edge n+1+TURN_CYCLES).
REQ-025 SHALL ignore a non-owner's req during SETUP/ACTIVE; it is served after DRAIN.
REQ-026 SHALL treat owner req dropping during SETUP as completing SETUP, one ACTIVE cycle, then DRAIN (no abort of the turnaround).
REQ-027 SHALL, after a timeout with both reqs high, grant the other side next.

Reset
REQ-028 SHALL, while rst_n is low at a clock edge, force state IDLE, noe=1, dir=1, gnt_a=0, gnt_b=0, busy=0, timeout=0, counters 0, last_owner=B (A wins first tie).
REQ-029 SHALL, on reset asserted mid-ACTIVE, drive noe=1 and both gnts 0 from the next edge, with no DRAIN cycle.

Verification
REQ-030 SHALL cover: reset, req_a=1 at edge 0 -> busy=1 edge 1, dir=1 noe=1 edges 1-2, gnt_a=1 noe=0 from edge 3.
REQ-031 SHALL cover: req_a and req_b rise same edge after reset -> A granted first; A drops -> 1 DRAIN cycle, 2 SETUP with dir=0, then gnt_b=1.
REQ-032 SHALL cover: HOLD_MAX=16, req_a held high, req_b high -> gnt_a high exactly 16 cycles, timeout pulse 1 cycle, then gnt_b.
REQ-033 SHALL cover: HOLD_MAX=0, req_b held 300 cycles -> gnt_b continuous, timeout never pulses.
REQ-034 SHALL cover: rst_n low during gnt_b -> next edge noe=1, gnt_b=0, dir=1, state IDLE.
REQ-035 SHALL cover, in every test: no cycle with gnt_a&gnt_b, no dir change while noe=0.
